instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/instr_fifo.sv | 64 ++++++
 rtl/instr_fetch.sv | 157 +++++++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state enum, instruction byte field positions
// and the decoded instruction record carried through the fetch buffer.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_REG,
    FETCH_IMM1,
    FETCH_IMM2
  } fetch_state_e;

  // byte0 = {dst, opcode}
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_MSB  = 4;
  localparam int unsigned DST_LSB = 5;
  localparam int unsigned DST_MSB = 7;

  // byte1 = {hasimm1, hasimm2, src1, src2}
  localparam int unsigned HASIMM1_BIT = 7;
  localparam int unsigned HASIMM2_BIT = 6;
  localparam int unsigned SRC1_LSB    = 3;
  localparam int unsigned SRC1_MSB    = 5;
  localparam int unsigned SRC2_LSB    = 0;
  localparam int unsigned SRC2_MSB    = 2;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  dst;
    logic        hasimm1;
    logic        hasimm2;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [7:0]  imm1;
    logic [7:0]  imm2;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } instr_t;

endpackage

// File: rtl/instr_fifo.sv
// Small shift-register buffer of decoded instructions; head is always slot 0.
// flush empties it, reset also clears the payload so the head reads as zero.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   sync_rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  instr_t din,
  output instr_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  instr_t        mem       [DEPTH];
  instr_t        shift_src [DEPTH];
  logic          do_pop;
  logic          do_push;
  int unsigned   wr_pos;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[0];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Write slot accounts for the shift caused by a same-cycle pop.
  always_comb begin
    wr_pos = 32'(count);
    if (do_pop) wr_pos = 32'(count) - 1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g + 1 < DEPTH) begin : g_mid
      assign shift_src[g] = mem[g+1];
    end else begin : g_last
      assign shift_src[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_pop) mem[i] <= shift_src[i];
        if (do_push && (wr_pos == i)) mem[i] <= din;
      end
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch/assemble stage feeding a decoded-instruction buffer.
// Define IFETCH_BUF2_EN for a 2-entry buffer; default build uses a single entry.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        sync_rst,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [2:0]  out_dst,
  output logic        out_hasimm1,
  output logic        out_hasimm2,
  output logic [2:0]  out_src1,
  output logic [2:0]  out_src2,
  output logic [7:0]  out_imm1,
  output logic [7:0]  out_imm2,
  output logic [15:0] out_pc,
  output logic [15:0] out_next_pc
);

`ifdef IFETCH_BUF2_EN
  localparam int unsigned BUF_DEPTH = 2;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  fetch_state_e state, state_n;
  logic [15:0]  fetch_pc, fetch_pc_n, start_pc;
  logic [7:0]   op_q, reg_q, imm1_q, reg_byte;
  logic         cap_op, cap_reg, cap_imm1, push_req;
  logic         buf_empty, buf_full;
  instr_t       asm_instr, head;

  assign rom_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state    <= FETCH_OP;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      state    <= FETCH_OP;
      fetch_pc <= redirect_pc;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      op_q     <= '0;
      reg_q    <= '0;
      imm1_q   <= '0;
      start_pc <= '0;
    end else begin
      if (cap_op) begin
        op_q     <= rom_data;
        start_pc <= fetch_pc;
      end
      if (cap_reg)  reg_q  <= rom_data;
      if (cap_imm1) imm1_q <= rom_data;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    cap_op     = 1'b0;
    cap_reg    = 1'b0;
    cap_imm1   = 1'b0;
    push_req   = 1'b0;
    unique case (state)
      FETCH_OP: begin
        // Occupancy is taken at the start of the cycle; a same-cycle pop does not free a slot.
        if (!buf_full) begin
          cap_op     = 1'b1;
          fetch_pc_n = fetch_pc + 16'd1;
          state_n    = FETCH_REG;
        end
      end
      FETCH_REG: begin
        cap_reg    = 1'b1;
        fetch_pc_n = fetch_pc + 16'd1;
        if (rom_data[HASIMM1_BIT])      state_n = FETCH_IMM1;
        else if (rom_data[HASIMM2_BIT]) state_n = FETCH_IMM2;
        else begin
          push_req = 1'b1;
          state_n  = FETCH_OP;
        end
      end
      FETCH_IMM1: begin
        cap_imm1   = 1'b1;
        fetch_pc_n = fetch_pc + 16'd1;
        if (reg_q[HASIMM2_BIT]) state_n = FETCH_IMM2;
        else begin
          push_req = 1'b1;
          state_n  = FETCH_OP;
        end
      end
      FETCH_IMM2: begin
        fetch_pc_n = fetch_pc + 16'd1;
        push_req   = 1'b1;
        state_n    = FETCH_OP;
      end
      default: state_n = FETCH_OP;
    endcase
  end

  // The final byte of an instruction is merged straight from rom_data into the pushed record.
  always_comb begin
    reg_byte          = (state == FETCH_REG) ? rom_data : reg_q;
    asm_instr         = '0;
    asm_instr.opcode  = op_q[OP_MSB:OP_LSB];
    asm_instr.dst     = op_q[DST_MSB:DST_LSB];
    asm_instr.hasimm1 = reg_byte[HASIMM1_BIT];
    asm_instr.hasimm2 = reg_byte[HASIMM2_BIT];
    asm_instr.src1    = reg_byte[SRC1_MSB:SRC1_LSB];
    asm_instr.src2    = reg_byte[SRC2_MSB:SRC2_LSB];
    asm_instr.imm1    = (state == FETCH_IMM1) ? rom_data
                      : (reg_byte[HASIMM1_BIT] ? imm1_q : 8'h00);
    asm_instr.imm2    = (state == FETCH_IMM2) ? rom_data : 8'h00;
    asm_instr.pc      = start_pc;
    asm_instr.next_pc = fetch_pc + 16'd1;
  end

  instr_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .sync_rst (sync_rst),
    .push     (push_req && !redirect_valid),
    .pop      (out_valid && out_ready),
    .flush    (redirect_valid),
    .din      (asm_instr),
    .head     (head),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign out_valid   = !buf_empty;
  assign out_opcode  = head.opcode;
  assign out_dst     = head.dst;
  assign out_hasimm1 = head.hasimm1;
  assign out_hasimm2 = head.hasimm2;
  assign out_src1    = head.src1;
  assign out_src2    = head.src2;
  assign out_imm1    = head.imm1;
  assign out_imm2    = head.imm2;
  assign out_pc      = head.pc;
  assign out_next_pc = head.next_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: ROM model, expected-instruction queue,
// latency, hold, redirect, wrap and mid-instruction reset scenarios.
module tb_instr_fetch;

`ifdef IFETCH_BUF2_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        sync_rst;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_dst;
  logic        out_hasimm1, out_hasimm2;
  logic [2:0]  out_src1, out_src2;
  logic [7:0]  out_imm1, out_imm2;
  logic [15:0] out_pc, out_next_pc;

  logic [7:0]  rom [65536];
  logic [63:0] exp_q [$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_dst        (out_dst),
    .out_hasimm1    (out_hasimm1),
    .out_hasimm2    (out_hasimm2),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .out_imm1       (out_imm1),
    .out_imm2       (out_imm2),
    .out_pc         (out_pc),
    .out_next_pc    (out_next_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Writes one encoded instruction into the ROM; optionally queues its expected decode.
  task automatic add_instr(input logic [15:0] addr, input logic [4:0] op, input logic [2:0] dst,
                           input logic h1, input logic h2, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [7:0] i1, input logic [7:0] i2, input bit expect_it,
                           output logic [15:0] nxt);
    logic [15:0] a;
    a = addr;
    rom[a] = {dst, op};        a = a + 16'd1;
    rom[a] = {h1, h2, s1, s2}; a = a + 16'd1;
    if (h1) begin rom[a] = i1; a = a + 16'd1; end
    if (h2) begin rom[a] = i2; a = a + 16'd1; end
    nxt = a;
    if (expect_it)
      exp_q.push_back({op, dst, h1, h2, s1, s2, (h1 ? i1 : 8'h00), (h2 ? i2 : 8'h00), addr, a});
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready && exp_q.size() != 0)
      check("instr", {out_opcode, out_dst, out_hasimm1, out_hasimm2, out_src1, out_src2,
                      out_imm1, out_imm2, out_pc, out_next_pc}, exp_q.pop_front());
  end

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic redirect(input logic [15:0] pc);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nx;
    int unsigned n;
    sync_rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;

    // Basic program at the reset vector
    add_instr(16'h0000, 5'd1,  3'd1, 0, 0, 3'd1, 3'd0, 8'h00, 8'h00, 1, nx);
    add_instr(nx,       5'd15, 3'd0, 1, 1, 3'd0, 3'd0, 8'h34, 8'h12, 1, nx);
    add_instr(nx,       5'd3,  3'd2, 1, 0, 3'd4, 3'd5, 8'hA5, 8'h00, 1, nx);
    add_instr(nx,       5'd31, 3'd7, 0, 1, 3'd7, 3'd7, 8'h00, 8'h5A, 1, nx);
    @(posedge clk); @(negedge clk);
    check("rst_valid",  64'(out_valid),  64'd0);
    check("rst_addr",   64'(rom_addr),   64'h0000);
    check("rst_pc",     64'(out_pc),     64'h0000);
    check("rst_opcode", 64'(out_opcode), 64'd0);
    @(posedge clk); #1;
    sync_rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); check("lat_c0", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_c2", 64'(out_valid), 64'd1);
    drain(200);

    // 4-byte instruction latency after a redirect
    add_instr(16'h0080, 5'd2, 3'd3, 1, 1, 3'd1, 3'd2, 8'h34, 8'h12, 1, nx);
    redirect(16'h0080);
    out_ready = 1'b1;
    @(negedge clk);
    check("rd80_addr",  64'(rom_addr),  64'h0080);
    check("rd80_valid", 64'(out_valid), 64'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("lat4_c3", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat4_c4", 64'(out_valid), 64'd1);
    drain(200);

    // Back-pressure: buffer fills, fetch freezes on the next op byte
    nx = 16'h0100;
    for (int unsigned k = 0; k < 4; k++)
      add_instr(nx, 5'(16 + k), 3'(k), 0, 0, 3'(k + 1), 3'(k + 2), 8'h00, 8'h00, 1, nx);
    redirect(16'h0100);
    repeat (30) @(negedge clk);
    check("hold_addr",  64'(rom_addr),  64'(16'h0100 + 16'(2 * DEPTH)));
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_pc",    64'(out_pc),    64'h0100);
    drain(200);

    // Redirect while assembling an immediate
    add_instr(16'h0200, 5'd4, 3'd1, 0, 0, 3'd2, 3'd3, 8'h00, 8'h00, (DEPTH == 1), nx);
    add_instr(nx,       5'd5, 3'd2, 1, 1, 3'd3, 3'd4, 8'h11, 8'h22, 0, nx);
    add_instr(16'h0040, 5'd6, 3'd3, 1, 0, 3'd5, 3'd6, 8'h99, 8'h00, 0, nx);
    add_instr(nx,       5'd7, 3'd4, 0, 0, 3'd6, 3'd7, 8'h00, 8'h00, 0, nx);
    redirect(16'h0200);
    if (DEPTH == 1) out_ready = 1'b1;
    n = 0;
    while (rom_addr != 16'h0204 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_imm1", 64'(rom_addr), 64'h0204);
    redirect_valid = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd40_valid", 64'(out_valid), 64'd0);
    check("rd40_addr",  64'(rom_addr),  64'h0040);
    add_instr(16'h0040, 5'd6, 3'd3, 1, 0, 3'd5, 3'd6, 8'h99, 8'h00, 1, nx);
    add_instr(nx,       5'd7, 3'd4, 0, 0, 3'd6, 3'd7, 8'h00, 8'h00, 1, nx);
    drain(200);

    // Instruction spanning the address wrap
    add_instr(16'hFFFE, 5'd8, 3'd1, 1, 0, 3'd2, 3'd3, 8'h77, 8'h00, 1, nx);
    add_instr(nx,       5'd9, 3'd5, 0, 0, 3'd1, 3'd1, 8'h00, 8'h00, 1, nx);
    redirect(16'hFFFE);
    out_ready = 1'b1;
    @(negedge clk); check("wrap_a0", 64'(rom_addr), 64'hFFFE);
    @(negedge clk); check("wrap_a1", 64'(rom_addr), 64'hFFFF);
    @(negedge clk); check("wrap_a2", 64'(rom_addr), 64'h0000);
    drain(200);

    // Reset while in FETCH_REG
    add_instr(16'h0300, 5'd10, 3'd1, 0, 0, 3'd1, 3'd1, 8'h00, 8'h00, 0, nx);
    add_instr(16'h0000, 5'd11, 3'd2, 0, 0, 3'd3, 3'd4, 8'h00, 8'h00, 0, nx);
    add_instr(nx,       5'd12, 3'd6, 0, 1, 3'd5, 3'd2, 8'h00, 8'hC3, 0, nx);
    redirect(16'h0300);
    @(posedge clk); #1;
    check("pre_rst_addr", 64'(rom_addr), 64'h0301);
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_addr",  64'(rom_addr),  64'h0000);
    check("mrst_npc",   64'(out_next_pc), 64'h0000);
    add_instr(16'h0000, 5'd11, 3'd2, 0, 0, 3'd3, 3'd4, 8'h00, 8'h00, 1, nx);
    add_instr(nx,       5'd12, 3'd6, 0, 1, 3'd5, 3'd2, 8'h00, 8'hC3, 1, nx);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
